// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types and constants for the ALU operation sequencer
//
// Contents:
//   BYTE_W             width of one TX FIFO byte
//   SHR_A/SHL_A/...    ALU shift function codes
//   state_t            sequencer state encoding (IDLE/ISSUE/SEND)

package alu_ctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic [3:0] SHR_A = 4'b1100;
    localparam logic [3:0] SHL_A = 4'b1101;
    localparam logic [3:0] SHR_B = 4'b1110;
    localparam logic [3:0] SHL_B = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one ALU command, collects the result, streams it LSB-first to the TX FIFO
//
// Ports:
//   clk, RST                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only while idle)
//   cmd_fun, cmd_A, cmd_B            command function code and operands
//   ALU_FUN, A, B, alu_enable        registered drive to the ALU unit
//   alu_out, alu_flag                ALU result and done flag
//   wr_data, wr_inc, fifo_full       TX FIFO write port
//   timeout_err                      one-cycle pulse when the done flag never arrives

module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int OPERAND_LEN = 16,
    parameter int RESULT_LEN  = 16,
    parameter int WAIT_MAX    = 15
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_fun,
    input  logic [OPERAND_LEN-1:0] cmd_A,
    input  logic [OPERAND_LEN-1:0] cmd_B,
    output logic [3:0]             ALU_FUN,
    output logic [OPERAND_LEN-1:0] A,
    output logic [OPERAND_LEN-1:0] B,
    output logic                   alu_enable,
    input  logic [RESULT_LEN-1:0]  alu_out,
    input  logic                   alu_flag,
    output logic [BYTE_W-1:0]      wr_data,
    output logic                   wr_inc,
    input  logic                   fifo_full,
    output logic                   timeout_err
);

    localparam int NUM_BYTES = RESULT_LEN / BYTE_W;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_W     = $clog2(WAIT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

    state_t                   state_q,       state_d;
    logic                     cmd_ready_q,   cmd_ready_d;
    logic [3:0]               alu_fun_q,     alu_fun_d;
    logic [OPERAND_LEN-1:0]   a_q,           a_d;
    logic [OPERAND_LEN-1:0]   b_q,           b_d;
    logic                     alu_enable_q,  alu_enable_d;
    logic [RESULT_LEN-1:0]    result_q,      result_d;
    logic [IDX_W-1:0]         idx_q,         idx_d;
    logic [CNT_W-1:0]         cnt_q,         cnt_d;
    logic                     timeout_err_q, timeout_err_d;

    logic                     accept;
    logic                     write;
    logic [CNT_W-1:0]         cnt_inc;
    logic [BYTE_W-1:0]        byte_sel;

    // cmd_ready_q is a registered copy of "next state is IDLE", so it is
    // low throughout reset and rises at the first edge after release.
    assign accept  = (state_q == IDLE) && cmd_ready_q && cmd_valid;
    assign write   = (state_q == SEND) && !fifo_full;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Byte select: plain index mux over the captured result.
    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                byte_sel = result_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_fun_d     = alu_fun_q;
        a_d           = a_q;
        b_d           = b_q;
        alu_enable_d  = alu_enable_q;
        result_d      = result_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_fun_d    = cmd_fun;
                    a_d          = cmd_A;
                    b_d          = cmd_B;
                    alu_enable_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d = cnt_inc;
                // A done flag on the same edge the limit is reached still wins.
                if (alu_flag) begin
                    result_d     = alu_out;
                    alu_enable_d = 1'b0;
                    idx_d        = '0;
                    state_d      = SEND;
                end else if (cnt_inc == WAIT_LIMIT) begin
                    result_d      = '0;
                    timeout_err_d = 1'b1;
                    alu_enable_d  = 1'b0;
                    idx_d         = '0;
                    state_d       = SEND;
                end
            end

            SEND: begin
                if (write) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            alu_fun_q     <= '0;
            a_q           <= '0;
            b_q           <= '0;
            alu_enable_q  <= 1'b0;
            result_q      <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            alu_fun_q     <= alu_fun_d;
            a_q           <= a_d;
            b_q           <= b_d;
            alu_enable_q  <= alu_enable_d;
            result_q      <= result_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign ALU_FUN     = alu_fun_q;
    assign A           = a_q;
    assign B           = b_q;
    assign alu_enable  = alu_enable_q;
    assign timeout_err = timeout_err_q;
    assign wr_inc      = write;
    assign wr_data     = (state_q == SEND) ? byte_sel : '0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU unit

module tb_alu_op_sequencer;
    import alu_ctrl_pkg::*;

    localparam int OL = 16;
    localparam int RL = 16;
    localparam int WM = 15;
    localparam int NB = RL / BYTE_W;

    logic          clk;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_fun;
    logic [OL-1:0] cmd_A;
    logic [OL-1:0] cmd_B;
    logic [3:0]    ALU_FUN;
    logic [OL-1:0] A;
    logic [OL-1:0] B;
    logic          alu_enable;
    logic [RL-1:0] alu_out;
    logic          alu_flag;
    logic [7:0]    wr_data;
    logic          wr_inc;
    logic          fifo_full = 1'b0;
    logic          timeout_err;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int unsigned cyc       = 0;
    int unsigned wr_seen   = 0;
    int unsigned to_count  = 0;
    int unsigned to_cyc    = 0;
    int unsigned en_cycles = 0;
    bit          mute       = 1'b0;
    bit          rand_full  = 1'b0;
    bit          force_full = 1'b0;

    alu_op_sequencer #(
        .OPERAND_LEN (OL),
        .RESULT_LEN  (RL),
        .WAIT_MAX    (WM)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_fun     (cmd_fun),
        .cmd_A       (cmd_A),
        .cmd_B       (cmd_B),
        .ALU_FUN     (ALU_FUN),
        .A           (A),
        .B           (B),
        .alu_enable  (alu_enable),
        .alu_out     (alu_out),
        .alu_flag    (alu_flag),
        .wr_data     (wr_data),
        .wr_inc      (wr_inc),
        .fifo_full   (fifo_full),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // What the ALU is supposed to compute for a command.
    function automatic logic [RL-1:0] alu_model(input logic [3:0] f, input logic [OL-1:0] a,
                                                input logic [OL-1:0] b);
        case (f)
            SHR_A:   return RL'(a) >> 1;
            SHL_A:   return RL'(a) << 1;
            SHR_B:   return RL'(b) >> 1;
            SHL_B:   return RL'(b) << 1;
            4'd0:    return RL'(a) + RL'(b);
            4'd1:    return RL'(a) - RL'(b);
            4'd2:    return RL'(a) & RL'(b);
            4'd3:    return RL'(a) ^ RL'(b);
            default: return RL'(a) | RL'(b);
        endcase
    endfunction

    // Behavioural execution unit: done flag registered one cycle after enable is sampled.
    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            alu_flag <= 1'b0;
            alu_out  <= '0;
        end else begin
            alu_flag <= alu_enable && !mute;
            if (alu_enable) alu_out <= alu_model(ALU_FUN, A, B);
        end
    end

    // FIFO backpressure changes just after the active edge so it is stable at sampling.
    always @(posedge clk) begin
        #1;
        fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard push: every accepted command yields its result bytes, LSB first.
    always @(posedge clk) begin
        if (RST && cmd_valid && cmd_ready) begin : push_blk
            logic [RL-1:0] r;
            r = mute ? '0 : alu_model(cmd_fun, cmd_A, cmd_B);
            for (int i = 0; i < NB; i++) exp_q.push_back(r[i*8 +: 8]);
        end
    end

    // Monitor: pop and compare on every FIFO write.
    always @(negedge clk) begin
        if (RST && wr_inc) begin
            check("queue_has_byte", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
            wr_seen++;
        end
        if (RST && timeout_err) begin
            to_count++;
            to_cyc = cyc;
        end
        if (RST && alu_enable) en_cycles++;
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic [3:0] f, input logic [OL-1:0] a, input logic [OL-1:0] b,
                         input bit hold, output int unsigned t_acc);
        int n;
        n = 0;
        cmd_fun   = f;
        cmd_A     = a;
        cmd_B     = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        t_acc = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          n;
        int unsigned t0, t1, w0, e0, c0;
        logic [3:0]  rf;
        logic [OL-1:0] ra;

        RST = 1'b0; cmd_valid = 1'b0; cmd_fun = '0; cmd_A = '0; cmd_B = '0;
        #12;
        check("rst_cmd_ready",   32'(cmd_ready),   32'd0);
        check("rst_alu_fun",     32'(ALU_FUN),     32'd0);
        check("rst_A",           32'(A),           32'd0);
        check("rst_B",           32'(B),           32'd0);
        check("rst_alu_enable",  32'(alu_enable),  32'd0);
        check("rst_wr_data",     32'(wr_data),     32'd0);
        check("rst_wr_inc",      32'(wr_inc),      32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Shift right A: 0x00F0 -> 0x0078
        w0 = wr_seen; e0 = en_cycles;
        issue(SHR_A, 16'h00F0, OL'($urandom), 1'b0, t0);
        check("t1_alu_fun", 32'(ALU_FUN), 32'(SHR_A));
        check("t1_A", 32'(A), 32'h00F0);
        check("t1_enable", 32'(alu_enable), 32'd1);
        wait_ready(n);
        check("t1_ready_return", 32'(n), 32'd5);
        check("t1_enable_cycles", en_cycles - e0, 32'd2);
        check("t1_writes", wr_seen - w0, 32'(NB));

        // Shift left B with FIFO full across SEND entry
        w0 = wr_seen;
        issue(SHL_B, OL'($urandom), 16'h8001, 1'b0, t0);
        force_full = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("t2_stall_wr_inc", 32'(wr_inc), 32'd0);
            check("t2_stall_data", 32'(wr_data), 32'h02);
            @(negedge clk);
        end
        force_full = 1'b0;
        wait_ready(n);
        check("t2_ready", 32'(cmd_ready), 32'd1);
        check("t2_writes", wr_seen - w0, 32'(NB));

        // Done flag never arrives
        mute = 1'b1;
        w0 = wr_seen; c0 = to_count;
        issue(4'(($urandom)), OL'($urandom), OL'($urandom), 1'b0, t0);
        wait_ready(n);
        check("t3_timeout_count", to_count - c0, 32'd1);
        check("t3_timeout_delay", to_cyc - t0, 32'(WM));
        check("t3_ready_return", 32'(n), 32'(WM + 3));
        check("t3_writes", wr_seen - w0, 32'(NB));
        mute = 1'b0;

        // Back-to-back with valid held
        w0 = wr_seen;
        issue(SHL_A, OL'($urandom), OL'($urandom), 1'b1, t0);
        issue(4'd0, OL'($urandom), OL'($urandom), 1'b0, t1);
        check("t4_spacing", t1 - t0, 32'd5);
        wait_ready(n);
        check("t4_writes", wr_seen - w0, 32'(2 * NB));

        // Reset during SEND after the first byte
        w0 = wr_seen;
        issue(4'd3, OL'($urandom), OL'($urandom), 1'b0, t0);
        n = 0;
        while (!wr_inc && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_send", 32'(wr_inc), 32'd1);
        @(posedge clk);
        #1 RST = 1'b0;
        #1;
        check("t5_rst_wr_inc",     32'(wr_inc),      32'd0);
        check("t5_rst_wr_data",    32'(wr_data),     32'd0);
        check("t5_rst_alu_fun",    32'(ALU_FUN),     32'd0);
        check("t5_rst_A",          32'(A),           32'd0);
        check("t5_rst_enable",     32'(alu_enable),  32'd0);
        check("t5_rst_cmd_ready",  32'(cmd_ready),   32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("t5_single_write", wr_seen - w0, 32'd1);
        RST = 1'b1;
        w0 = wr_seen;
        issue(SHR_B, OL'($urandom), 16'h1234, 1'b0, t0);
        wait_ready(n);
        check("t5_next_ready_return", 32'(n), 32'd5);
        check("t5_next_writes", wr_seen - w0, 32'(NB));

        // Stray valid during ISSUE
        w0 = wr_seen;
        rf = 4'(($urandom));
        ra = OL'($urandom);
        issue(rf, ra, OL'($urandom), 1'b0, t0);
        cmd_fun = ~rf; cmd_A = ~ra; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t6_alu_fun_held", 32'(ALU_FUN), 32'(rf));
        check("t6_A_held", 32'(A), 32'(ra));
        wait_ready(n);
        repeat (3) @(negedge clk);
        check("t6_writes", wr_seen - w0, 32'(NB));

        // Random traffic with random backpressure and occasional timeouts
        rand_full = 1'b1;
        for (int k = 0; k < 25; k++) begin
            mute = ($urandom_range(0, 5) == 0);
            issue(4'(($urandom)), OL'($urandom), OL'($urandom), 1'b0, t0);
            wait_ready(n);
            check("rnd_ready", 32'(cmd_ready), 32'd1);
            mute = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_full = 1'b0;

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issuing side of the ALU execution-unit handshake. Accepts one operation command (function code plus two operands) over a valid/ready port. Drives the ALU function code, operands and unit enable, then waits for the unit's done flag and captures the result. Streams the result as bytes, LSB first, into the TX FIFO write port, honouring the FIFO full flag. Sits between the system controller's command decode and the ALU/TX FIFO.

## Interface
- OPERAND_LEN, 16, width of operands A and B
- RESULT_LEN, 16, ALU result width; must be a multiple of 8
- WAIT_MAX, 15, cycles to wait for the done flag before declaring timeout (must be ≥ 2)

Ports:
- clk  in  1  single clock
- RST  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle and able to accept
- cmd_fun  in  4  ALU function code
- cmd_A  in  OPERAND_LEN  operand A
- cmd_B  in  OPERAND_LEN  operand B
- ALU_FUN  out  4  function code to ALU, registered
- A  out  OPERAND_LEN  operand A to ALU, registered
- B  out  OPERAND_LEN  operand B to ALU, registered
- alu_enable  out  1  unit enable, registered
- alu_out  in  RESULT_LEN  unit result
- alu_flag  in  1  unit done flag (registered in unit, one cycle after enable sampled)
- wr_data  out  8  byte to TX FIFO
- wr_inc  out  1  FIFO write strobe, one byte per cycle high
- fifo_full  in  1  FIFO cannot accept
- timeout_err  out  1  one-cycle pulse on done-flag timeout

## Operation
States: IDLE, ISSUE, SEND.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_fun/cmd_A/cmd_B into ALU_FUN/A/B, set alu_enable=1, clear wait counter, go to ISSUE.
- ISSUE:
  - alu_enable held 1; wait counter increments each cycle.
  - alu_flag=1: capture alu_out into the result register, alu_enable=0, byte index=0, go to SEND.
  - Counter reaches WAIT_MAX with alu_flag=0: result register=0, timeout_err pulses 1 cycle, alu_enable=0, go to SEND.
- SEND:
  - wr_data = result byte[index], combinational from the result register and index.
  - wr_inc = !fifo_full; index increments on each write.
  - After the write of byte RESULT_LEN/8−1: go to IDLE.
  - fifo_full stalls indefinitely with wr_data stable.
- ALU_FUN/A/B hold their value until the next accepted command.
- Reset values: cmd_ready=0 during reset and 1 after reset in IDLE. ALU_FUN, A, B, alu_enable, wr_data, wr_inc and timeout_err are all 0. State is IDLE and the result register is 0.
- Reset mid-operation: asynchronous return to IDLE. A partially sent result is discarded and no further wr_inc is issued.
- cmd_valid outside IDLE is ignored (cmd_ready=0). The command is not lost only if the source holds valid.
- alu_flag seen outside ISSUE is ignored.

## Timing
- Accept at edge E0. alu_enable=1 from E0.
- The unit samples enable at E1, so alu_flag=1 in the cycle after E1. Result is captured at E2, and alu_enable drops after E2.
- First wr_inc in the cycle after E2 (if not full). Last byte is written at E2+RESULT_LEN/8 with no stalls.
- cmd_ready returns after the final write edge.
- Minimum command-to-command spacing with no stalls: 3 + RESULT_LEN/8 cycles (5 for 16-bit).
- Timeout asserts at the edge where the counter equals WAIT_MAX. timeout_err is high for the following cycle.

## Structure
- Shared package alu_ctrl_pkg:
  - state enum (IDLE/ISSUE/SEND)
  - function code constants SHR_A=4'b1100, SHL_A=4'b1101, SHR_B=4'b1110, SHL_B=4'b1111
  - BYTE_W=8
- Single module. Byte select is an index mux with no sub-module. Wait counter width is $clog2(WAIT_MAX+1).

## Test plan
- Reset, then cmd_fun=4'b1100, A=16'h00F0 with a behavioural shift unit → ALU_FUN=1100 and alu_enable high for 2 cycles. Bytes 8'h78 then 8'h00 on consecutive wr_inc cycles. cmd_ready returns 5 cycles after accept.
- cmd_fun=4'b1111, B=16'h8001, fifo_full held high for 4 cycles in SEND → wr_inc stays 0 and wr_data stays 8'h02 throughout. Then 8'h02 and 8'h00 are written.
- alu_flag tied 0 → timeout_err pulses once WAIT_MAX cycles after accept. Bytes 8'h00, 8'h00 written. Sequencer returns to IDLE.
- Back-to-back commands with cmd_valid held → second accept exactly 5 cycles after the first. No byte is duplicated or dropped.
- RST pulsed low during SEND after the first byte → outputs zero immediately. No second wr_inc. Next command completes normally.
- cmd_valid pulsed during ISSUE → ignored. Only the first command's two bytes appear.
